// File: rtl/gate_mux_pkg.sv
// Shared types for the gate-mux arbiter: opcodes, FSM states and the per-bit
// mux data-input selects, plus a helper that resolves a select to a bit.
package gate_mux_pkg;

   typedef enum logic [2:0] {
      OP_AND  = 3'd0,
      OP_OR   = 3'd1,
      OP_XOR  = 3'd2,
      OP_XNOR = 3'd3,
      OP_NAND = 3'd4,
      OP_NOR  = 3'd5
   } op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_e;

   typedef enum logic [1:0] {
      ZERO = 2'd0,
      ONE  = 2'd1,
      B    = 2'd2,
      NB   = 2'd3
   } sel_e;

   function automatic logic sel_bit(input sel_e sel, input logic b_bit);
      case (sel)
         ZERO:    return 1'b0;
         ONE:     return 1'b1;
         B:       return b_bit;
         default: return ~b_bit;
      endcase
   endfunction

   // Opcodes 6 and 7 have no enum member and produce a zero result.
   function automatic logic is_illegal_op(input logic [2:0] op);
      return op > 3'd5;
   endfunction

endpackage

// File: rtl/mux_gate_unit.sv
// Combinational logic unit: every result bit is a 2:1 mux selected by a[k],
// with the two data inputs chosen from {0, 1, b[k], ~b[k]} by the opcode.
module mux_gate_unit
   import gate_mux_pkg::*;
#(
   parameter int W = 8
) (
   input  logic [2:0]   op,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] y
);

   sel_e d1;
   sel_e d0;

   // Illegal opcodes keep both selects at ZERO, forcing y to 0.
   always_comb begin
      d1 = ZERO;
      d0 = ZERO;
      case (op_e'(op))
         OP_AND:  begin d1 = B;    d0 = ZERO; end
         OP_OR:   begin d1 = ONE;  d0 = B;    end
         OP_XOR:  begin d1 = NB;   d0 = B;    end
         OP_XNOR: begin d1 = B;    d0 = NB;   end
         OP_NAND: begin d1 = NB;   d0 = ONE;  end
         OP_NOR:  begin d1 = ZERO; d0 = NB;   end
         default: begin d1 = ZERO; d0 = ZERO; end
      endcase
   end

   always_comb begin
      y = '0;
      for (int k = 0; k < W; k++) begin
         y[k] = a[k] ? sel_bit(d1, b[k]) : sel_bit(d0, b[k]);
      end
   end

endmodule

// File: rtl/gate_mux_arbiter.sv
// Round-robin arbiter feeding a single mux-based logic unit; one transaction in
// flight (IDLE -> EXEC -> RESP). Define GATE_MUX_ERR_EN to add the rsp_err output.
module gate_mux_arbiter
   import gate_mux_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int W    = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NREQ-1:0]          req_valid,
   output logic [NREQ-1:0]          req_ready,
   input  logic [3*NREQ-1:0]        req_op,
   input  logic [W*NREQ-1:0]        req_a,
   input  logic [W*NREQ-1:0]        req_b,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [$clog2(NREQ)-1:0]  rsp_id,
   output logic [W-1:0]             rsp_y,
   output logic                     busy
`ifdef GATE_MUX_ERR_EN
   ,
   output logic                     rsp_err
`endif
);

   localparam int IW = $clog2(NREQ);

   state_e         state;
   state_e         state_next;
   logic [IW-1:0]  ptr;
   logic           found;
   logic [IW-1:0]  gnt_idx;
   logic [2:0]     gnt_op;
   logic [W-1:0]   gnt_a;
   logic [W-1:0]   gnt_b;
   logic [2:0]     lat_op;
   logic [W-1:0]   lat_a;
   logic [W-1:0]   lat_b;
   logic [IW-1:0]  lat_id;
   logic [W-1:0]   unit_y;

   // Search upward from ptr with wrap-around; the first valid requester wins.
   always_comb begin : grant_search
      int j;
      found   = 1'b0;
      gnt_idx = '0;
      gnt_op  = '0;
      gnt_a   = '0;
      gnt_b   = '0;
      for (int k = 0; k < NREQ; k++) begin
         j = int'(ptr) + k;
         if (j >= NREQ) j = j - NREQ;
         if (!found && req_valid[j]) begin
            found   = 1'b1;
            gnt_idx = IW'(j);
            gnt_op  = req_op[3*j +: 3];
            gnt_a   = req_a[W*j +: W];
            gnt_b   = req_b[W*j +: W];
         end
      end
   end

   always_comb begin
      req_ready = '0;
      if (state == IDLE && found) req_ready[gnt_idx] = 1'b1;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (found) state_next = EXEC;
         EXEC:    state_next = RESP;
         RESP:    if (rsp_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   assign busy = (state != IDLE);

   mux_gate_unit #(.W(W)) u_unit (
      .op (lat_op),
      .a  (lat_a),
      .b  (lat_b),
      .y  (unit_y)
   );

   // Reset drops any in-flight transaction without issuing a response.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         ptr       <= '0;
         rsp_valid <= 1'b0;
         rsp_y     <= '0;
         rsp_id    <= '0;
         lat_op    <= '0;
         lat_a     <= '0;
         lat_b     <= '0;
         lat_id    <= '0;
`ifdef GATE_MUX_ERR_EN
         rsp_err   <= 1'b0;
`endif
      end else begin
         state <= state_next;
         case (state)
            IDLE: begin
               if (found) begin
                  lat_op <= gnt_op;
                  lat_a  <= gnt_a;
                  lat_b  <= gnt_b;
                  lat_id <= gnt_idx;
                  ptr    <= (gnt_idx == IW'(NREQ-1)) ? '0 : gnt_idx + IW'(1);
               end
            end
            EXEC: begin
               rsp_y     <= unit_y;
               rsp_id    <= lat_id;
               rsp_valid <= 1'b1;
`ifdef GATE_MUX_ERR_EN
               rsp_err   <= is_illegal_op(lat_op);
`endif
            end
            RESP: begin
               if (rsp_ready) rsp_valid <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_gate_mux_arbiter.sv
// Self-checking bench for gate_mux_arbiter: directed vector table, round-robin,
// backpressure and reset corner sequences, then randomized traffic vs. a model.
module tb_gate_mux_arbiter;

   localparam int NREQ = 4;
   localparam int W    = 8;

   logic                 clk;
   logic                 rst_n;
   logic [NREQ-1:0]      req_valid;
   logic [NREQ-1:0]      req_ready;
   logic [3*NREQ-1:0]    req_op;
   logic [W*NREQ-1:0]    req_a;
   logic [W*NREQ-1:0]    req_b;
   logic                 rsp_valid;
   logic                 rsp_ready;
   logic [1:0]           rsp_id;
   logic [W-1:0]         rsp_y;
   logic                 busy;
`ifdef GATE_MUX_ERR_EN
   logic                 rsp_err;
`endif

   gate_mux_arbiter #(.NREQ(NREQ), .W(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_op    (req_op),
      .req_a     (req_a),
      .req_b     (req_b),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_y     (rsp_y),
      .busy      (busy)
`ifdef GATE_MUX_ERR_EN
      ,
      .rsp_err   (rsp_err)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int compared   = 0;
   int mismatched = 0;
   int mdlPtr     = 0;

   logic [2:0]   opArr [NREQ];
   logic [W-1:0] aArr  [NREQ];
   logic [W-1:0] bArr  [NREQ];

   typedef struct {
      int           id;
      logic [2:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] y;
   } vec_t;

   vec_t vecs [9];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [NREQ-1:0] valid);
      req_valid = valid;
      for (int i = 0; i < NREQ; i++) begin
         req_op[3*i +: 3] = opArr[i];
         req_a[W*i +: W]  = aArr[i];
         req_b[W*i +: W]  = bArr[i];
      end
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Plain boolean meaning of each opcode; 6 and 7 give zero.
   function automatic logic [W-1:0] refResult(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      case (op)
         3'd0:    return a & b;
         3'd1:    return a | b;
         3'd2:    return a ^ b;
         3'd3:    return ~(a ^ b);
         3'd4:    return ~(a & b);
         3'd5:    return ~(a | b);
         default: return '0;
      endcase
   endfunction

   function automatic int refGrant(input logic [NREQ-1:0] mask);
      for (int k = 0; k < NREQ; k++) begin
         if (mask[(mdlPtr + k) % NREQ]) return (mdlPtr + k) % NREQ;
      end
      return -1;
   endfunction

   // One full transaction from an IDLE DUT whose inputs were just applied;
   // rsp_ready is held low for 'hold' RESP cycles before the handshake.
   task automatic serveOne(input logic [NREQ-1:0] mask, input int hold,
                           input logic [W-1:0] expY, input string tag);
      int   gid;
      logic expErr;
      gid    = refGrant(mask);
      expErr = (opArr[gid] >= 3'd6);
      #1;
      checkOutput({tag, " grant"}, 32'(req_ready), 32'(1 << gid));
      mdlPtr    = (gid + 1) % NREQ;
      rsp_ready = (hold == 0);
      tick();
      checkOutput({tag, " exec busy"}, 32'(busy), 32'd1);
      checkOutput({tag, " exec rsp_valid"}, 32'(rsp_valid), 32'd0);
      checkOutput({tag, " exec req_ready"}, 32'(req_ready), 32'd0);
      tick();
      for (int h = 0; h <= hold; h++) begin
         checkOutput({tag, " rsp_valid"}, 32'(rsp_valid), 32'd1);
         checkOutput({tag, " rsp_y"}, 32'(rsp_y), 32'(expY));
         checkOutput({tag, " rsp_id"}, 32'(rsp_id), 32'(gid));
         checkOutput({tag, " resp req_ready"}, 32'(req_ready), 32'd0);
`ifdef GATE_MUX_ERR_EN
         checkOutput({tag, " rsp_err"}, 32'(rsp_err), 32'(expErr));
`endif
         if (h == hold) rsp_ready = 1'b1;
         tick();
      end
      checkOutput({tag, " done rsp_valid"}, 32'(rsp_valid), 32'd0);
      checkOutput({tag, " done busy"}, 32'(busy), 32'd0);
   endtask

   task automatic doReset();
      rst_n = 1'b0;
      tick();
      rst_n  = 1'b1;
      mdlPtr = 0;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int expSeq [5];
      int gid;
      expSeq = '{0, 1, 2, 3, 0};

      vecs[0] = '{0, 3'd0, 8'hF0, 8'hCC, 8'hC0};
      vecs[1] = '{1, 3'd0, 8'hAA, 8'hCC, 8'h88};
      vecs[2] = '{2, 3'd1, 8'hAA, 8'hCC, 8'hEE};
      vecs[3] = '{3, 3'd2, 8'hAA, 8'hCC, 8'h66};
      vecs[4] = '{0, 3'd3, 8'hAA, 8'hCC, 8'h99};
      vecs[5] = '{1, 3'd4, 8'hAA, 8'hCC, 8'h77};
      vecs[6] = '{2, 3'd5, 8'hAA, 8'hCC, 8'h11};
      vecs[7] = '{3, 3'd7, 8'hAA, 8'hCC, 8'h00};
      vecs[8] = '{0, 3'd6, 8'hFF, 8'hFF, 8'h00};

      for (int i = 0; i < NREQ; i++) begin
         opArr[i] = '0;
         aArr[i]  = '0;
         bArr[i]  = '0;
      end
      rst_n     = 1'b0;
      rsp_ready = 1'b0;
      applyStimulus('0);
      repeat (3) tick();
      checkOutput("reset busy", 32'(busy), 32'd0);
      checkOutput("reset rsp_valid", 32'(rsp_valid), 32'd0);
      checkOutput("reset rsp_y", 32'(rsp_y), 32'd0);
      checkOutput("reset rsp_id", 32'(rsp_id), 32'd0);
      checkOutput("reset req_ready", 32'(req_ready), 32'd0);
`ifdef GATE_MUX_ERR_EN
      checkOutput("reset rsp_err", 32'(rsp_err), 32'd0);
`endif
      rst_n = 1'b1;
      tick();
      checkOutput("idle no request busy", 32'(busy), 32'd0);

      $display("[TB] directed vector table");
      for (int v = 0; v < 9; v++) begin
         opArr[vecs[v].id] = vecs[v].op;
         aArr[vecs[v].id]  = vecs[v].a;
         bArr[vecs[v].id]  = vecs[v].b;
         applyStimulus(4'(1 << vecs[v].id));
         serveOne(4'(1 << vecs[v].id), 0, vecs[v].y, $sformatf("vec%0d", v));
         applyStimulus('0);
      end

      $display("[TB] round-robin with all requesters valid");
      doReset();
      for (int i = 0; i < NREQ; i++) begin
         opArr[i] = 3'($urandom_range(0, 5));
         aArr[i]  = W'($urandom);
         bArr[i]  = W'($urandom);
      end
      applyStimulus('1);
      for (int n = 0; n < 5; n++) begin
         #1;
         checkOutput($sformatf("rr seq%0d", n), 32'(req_ready), 32'(1 << expSeq[n]));
         gid = refGrant('1);
         serveOne('1, 0, refResult(opArr[gid], aArr[gid], bArr[gid]), $sformatf("rr%0d", n));
         opArr[gid] = 3'($urandom_range(0, 5));
         aArr[gid]  = W'($urandom);
         bArr[gid]  = W'($urandom);
         applyStimulus('1);
      end
      applyStimulus('0);

      $display("[TB] backpressure");
      opArr[2] = 3'd2; aArr[2] = 8'h3C; bArr[2] = 8'h0F;
      opArr[0] = 3'd1; aArr[0] = 8'h11; bArr[0] = 8'h22;
      applyStimulus(4'b0101);
      gid = refGrant(4'b0101);
      serveOne(4'b0101, 5, refResult(opArr[gid], aArr[gid], bArr[gid]), "bp");
      applyStimulus('0);

      $display("[TB] reset during RESP");
      opArr[3] = 3'd2; aArr[3] = 8'h5A; bArr[3] = 8'hFF;
      applyStimulus(4'b1000);
      rsp_ready = 1'b0;
      #1;
      tick();
      tick();
      checkOutput("rst-mid rsp_valid before", 32'(rsp_valid), 32'd1);
      rst_n = 1'b0;
      opArr[1] = 3'd0; aArr[1] = 8'hFF; bArr[1] = 8'h81;
      opArr[2] = 3'd5; aArr[2] = 8'h00; bArr[2] = 8'h00;
      applyStimulus(4'b0110);
      tick();
      rst_n  = 1'b1;
      mdlPtr = 0;
      checkOutput("rst-mid rsp_valid", 32'(rsp_valid), 32'd0);
      checkOutput("rst-mid busy", 32'(busy), 32'd0);
      checkOutput("rst-mid rsp_y", 32'(rsp_y), 32'd0);
      checkOutput("rst-mid rsp_id", 32'(rsp_id), 32'd0);
      checkOutput("rst-mid lowest grant", 32'(req_ready), 32'b0010);
      serveOne(4'b0110, 0, 8'h81, "rst-mid next");
      applyStimulus('0);

      $display("[TB] randomized traffic");
      for (int t = 0; t < 40; t++) begin
         logic [NREQ-1:0] mask;
         if ($urandom_range(0, 3) == 0) begin
            applyStimulus('0);
            #1;
            checkOutput("rand idle req_ready", 32'(req_ready), 32'd0);
            tick();
            checkOutput("rand idle busy", 32'(busy), 32'd0);
         end
         for (int i = 0; i < NREQ; i++) begin
            opArr[i] = 3'($urandom_range(0, 7));
            aArr[i]  = W'($urandom);
            bArr[i]  = W'($urandom);
         end
         mask = 4'($urandom_range(1, 15));
         applyStimulus(mask);
         gid = refGrant(mask);
         serveOne(mask, int'($urandom_range(0, 3)),
                  refResult(opArr[gid], aArr[gid], bArr[gid]), $sformatf("rand%0d", t));
      end
      applyStimulus('0);
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
